// File: rtl/iterative_mul_div_unit_if.sv
// Start/Busy/Done handshake and operand/result bus of the iterative mul/div unit.
interface iterative_mul_div_unit_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [TAG_W-1:0] RdIn;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [TAG_W-1:0] RdOut;

    modport master (
        output Start, Op, OpA, OpB, RdIn,
        input  Busy, Done, Result, RdOut
    );

    modport slave (
        input  Start, Op, OpA, OpB, RdIn,
        output Busy, Done, Result, RdOut
    );
endinterface

// File: rtl/iterative_mul_div_unit.sv
// Iterative WIDTH-cycle multiply / restoring divide for the LEGv8 datapath.
// Define MULDIV_SDIV_EN to build signed division (Op=10); otherwise Op=10 returns 0.
module iterative_mul_div_unit #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input logic Clk,
    input logic Reset,
    iterative_mul_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_UDIV = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state;
    state_t stateNext;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       opReg;
    logic [TAG_W-1:0] rdReg;
    logic [WIDTH-1:0] accReg;
    logic [WIDTH-1:0] qReg;
    logic [WIDTH-1:0] bReg;
`ifdef MULDIV_SDIV_EN
    logic             negQ;
    logic             negLoad;
`endif

    logic             accept;
    logic             special;
    logic             lastIter;
    logic [WIDTH-1:0] loadQ;
    logic [WIDTH-1:0] loadB;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   remDiff;
    logic [WIDTH-1:0] accNext;
    logic [WIDTH-1:0] qNext;
    logic [WIDTH-1:0] resultNext;

    assign accept   = bus.Start && (state != RUN);
    assign lastIter = (cnt == CNT_W'(WIDTH - 1));

    // Ops that complete without iterating: result is forced to zero
    always_comb begin
        special = 1'b1;
        unique case (bus.Op)
            OP_MUL:  special = 1'b0;
            OP_UDIV: special = (bus.OpB == '0);
`ifdef MULDIV_SDIV_EN
            OP_SDIV: special = (bus.OpB == '0);
`else
            OP_SDIV: special = 1'b1;
`endif
            default: special = 1'b1;
        endcase
    end

    // Operand loading: MUL keeps multiplicand in bReg, multiplier in qReg
    always_comb begin
        loadQ = bus.OpA;
        loadB = bus.OpB;
`ifdef MULDIV_SDIV_EN
        negLoad = 1'b0;
`endif
        unique case (bus.Op)
            OP_MUL: begin
                loadQ = bus.OpB;
                loadB = bus.OpA;
            end
`ifdef MULDIV_SDIV_EN
            OP_SDIV: begin
                loadQ = bus.OpA[WIDTH-1] ? -bus.OpA : bus.OpA;
                loadB = bus.OpB[WIDTH-1] ? -bus.OpB : bus.OpB;
                negLoad = bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1];
            end
`endif
            default: begin
                loadQ = bus.OpA;
                loadB = bus.OpB;
            end
        endcase
    end

    // One iteration: MSB-first shift-add, or one restoring-divide step
    always_comb begin
        remShift = {accReg, qReg[WIDTH-1]};
        remDiff  = remShift - {1'b0, bReg};
        accNext  = accReg;
        qNext    = qReg;
        if (opReg == OP_MUL) begin
            accNext = {accReg[WIDTH-2:0], 1'b0}
                    + (qReg[WIDTH-1] ? bReg : '0);
            qNext   = {qReg[WIDTH-2:0], 1'b0};
        end else if (!remDiff[WIDTH]) begin
            accNext = remDiff[WIDTH-1:0];
            qNext   = {qReg[WIDTH-2:0], 1'b1};
        end else begin
            accNext = remShift[WIDTH-1:0];
            qNext   = {qReg[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        resultNext = qNext;
        if (opReg == OP_MUL) begin
            resultNext = accNext;
        end
`ifdef MULDIV_SDIV_EN
        else if (opReg == OP_SDIV && negQ) begin
            resultNext = -qNext;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (accept) stateNext = special ? DONE : RUN;
            RUN:  if (lastIter) stateNext = DONE;
            DONE: begin
                if (accept) stateNext = special ? DONE : RUN;
                else        stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.Busy = (state == RUN);
        bus.Done = (state == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt        <= '0;
            opReg      <= OP_MUL;
            rdReg      <= '0;
            accReg     <= '0;
            qReg       <= '0;
            bReg       <= '0;
            bus.Result <= '0;
            bus.RdOut  <= '0;
`ifdef MULDIV_SDIV_EN
            negQ       <= 1'b0;
`endif
        end else if (accept) begin
            cnt    <= '0;
            opReg  <= bus.Op;
            rdReg  <= bus.RdIn;
            accReg <= '0;
            qReg   <= loadQ;
            bReg   <= loadB;
`ifdef MULDIV_SDIV_EN
            negQ   <= negLoad;
`endif
            if (special) begin
                bus.Result <= '0;
                bus.RdOut  <= bus.RdIn;
            end
        end else if (state == RUN) begin
            cnt    <= cnt + CNT_W'(1);
            accReg <= accNext;
            qReg   <= qNext;
            if (lastIter) begin
                bus.Result <= resultNext;
                bus.RdOut  <= rdReg;
            end
        end
    end
endmodule

// File: tb/tb_iterative_mul_div_unit.sv
// Directed and random checks of iterative_mul_div_unit against an arithmetic model.
module tb_iterative_mul_div_unit;
    localparam int W = 64;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int tests = 0;
    int failed = 0;
    logic [63:0] lastResult = '0;
    logic [4:0] lastRd = '0;

    iterative_mul_div_unit_if #(.WIDTH(64), .TAG_W(5)) bus ();

    iterative_mul_div_unit #(.WIDTH(64), .TAG_W(5)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] refModel(input logic [1:0] op,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
        logic signed [63:0] q;
        case (op)
            2'b00: return a * b;
            2'b01: return (b == 0) ? 64'd0 : a / b;
`ifdef MULDIV_SDIV_EN
            2'b10: begin
                if (b == 0) return 64'd0;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                q = $signed(a) / $signed(b);
                return q;
            end
`endif
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit isSpecial(input logic [1:0] op, input logic [63:0] b);
        if (op == 2'b11) return 1'b1;
        if (op == 2'b00) return 1'b0;
`ifndef MULDIV_SDIV_EN
        if (op == 2'b10) return 1'b1;
`endif
        return (b == 0);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge of the Done cycle
    task automatic runOp(input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd,
                         input bit holdStart);
        logic [63:0] exp;
        bit spec;
        int busyCnt;
        int guard;
        exp = refModel(op, a, b);
        spec = isSpecial(op, b);
        bus.Start = 1'b1;
        bus.Op = op;
        bus.OpA = a;
        bus.OpB = b;
        bus.RdIn = rd;
        @(negedge Clk);
        if (!holdStart) bus.Start = 1'b0;
        bus.Op = 2'($urandom);
        bus.OpA = {$urandom, $urandom};
        bus.OpB = {$urandom, $urandom};
        bus.RdIn = 5'($urandom);
        busyCnt = 0;
        guard = 0;
        while (!bus.Done && guard < 3 * W) begin
            if (bus.Busy) begin
                if (busyCnt == 0) check("result_held_in_run", bus.Result, lastResult);
                busyCnt++;
                if (holdStart && busyCnt == W) bus.Start = 1'b0;
            end
            @(negedge Clk);
            guard++;
        end
        check("done", 64'(bus.Done), 64'd1);
        check("busy_with_done", 64'(bus.Busy), 64'd0);
        check("busy_cycles", 64'(busyCnt), spec ? 64'd0 : 64'(W));
        check("result", bus.Result, exp);
        check("rdout", 64'(bus.RdOut), 64'(rd));
        lastResult = exp;
        lastRd = rd;
    endtask

    task automatic idleStep();
        bus.Start = 1'b0;
        @(negedge Clk);
        check("done_one_cycle", 64'(bus.Done), 64'd0);
        check("idle_busy", 64'(bus.Busy), 64'd0);
        check("result_held", bus.Result, lastResult);
        check("rd_held", 64'(bus.RdOut), 64'(lastRd));
    endtask

    initial begin
        logic [1:0] op;
        logic [63:0] a;
        logic [63:0] b;
        bit sawDone;
        bit b2b;
        bus.Start = 1'b0;
        bus.Op = 2'b00;
        bus.OpA = '0;
        bus.OpB = '0;
        bus.RdIn = '0;

        repeat (2) @(negedge Clk);
        check("reset_busy", 64'(bus.Busy), 64'd0);
        check("reset_done", 64'(bus.Done), 64'd0);
        check("reset_result", bus.Result, 64'd0);
        check("reset_rdout", 64'(bus.RdOut), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        runOp(2'b00, 64'd7, 64'd6, 5'd3, 1'b0);
        idleStep();

        // Abort a MUL mid-run with an asynchronous reset
        bus.Start = 1'b1;
        bus.Op = 2'b00;
        bus.OpA = 64'd11;
        bus.OpB = 64'd13;
        bus.RdIn = 5'd9;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (10) @(negedge Clk);
        check("abort_busy_before", 64'(bus.Busy), 64'd1);
        #2 Reset = 1'b1;
        #1;
        check("abort_busy", 64'(bus.Busy), 64'd0);
        check("abort_done", 64'(bus.Done), 64'd0);
        check("abort_result", bus.Result, 64'd0);
        check("abort_rdout", 64'(bus.RdOut), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            if (bus.Done) sawDone = 1'b1;
        end
        check("no_done_after_abort", 64'(sawDone), 64'd0);
        lastResult = '0;
        lastRd = '0;

        runOp(2'b00, '1, '1, 5'd1, 1'b0);
        idleStep();
        runOp(2'b01, 64'd100, 64'd7, 5'd4, 1'b0);
        idleStep();
        runOp(2'b01, 64'd5, 64'd0, 5'd5, 1'b0);
        idleStep();
        runOp(2'b10, -64'd100, 64'd7, 5'd6, 1'b0);
        idleStep();
        runOp(2'b10, 64'h8000_0000_0000_0000, '1, 5'd7, 1'b0);
        idleStep();
        runOp(2'b11, 64'd50, 64'd5, 5'd8, 1'b0);
        idleStep();

        // Start held through RUN, then a back-to-back issue in the Done cycle
        runOp(2'b00, 64'd123, 64'd456, 5'd10, 1'b1);
        runOp(2'b01, 64'd9, 64'd3, 5'd11, 1'b0);
        idleStep();

        for (int n = 0; n < 16; n++) begin
            op = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = 64'($urandom_range(1, 1000));
                2: b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 1) == 0) a = 64'($signed(32'($urandom)));
            b2b = ($urandom_range(0, 1) == 1);
            runOp(op, a, b, 5'($urandom), !isSpecial(op, b) && ($urandom_range(0, 3) == 0));
            if (!b2b) idleStep();
        end
        idleStep();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
